wb_port_arbiter: RTL

Arbitrates the single register-file write port between the MEM/WB pipeline stage and an out-of-pipeline multi-cycle unit (MCU, e.g. mul/div). It sits downstream of the MEM/WB latch. It selects load data or the ALU result for pipeline writes, and buffers MCU results in a small FIFO. When MCU results starve, it requests a pipeline stall so that a bubble reaches WB.

---
 rtl/wb_arb_pkg.sv | 25 ++
 rtl/wb_fifo.sv | 66 ++++++
 rtl/wb_port_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared widths, select/state encodings and the MCU result entry type
// for the register-file write-port arbiter.
package wb_arb_pkg;

   localparam int DATA_W   = 32;
   localparam int REG_W    = 5;
   localparam int NUM_REGS = 1 << REG_W;

   typedef enum logic [1:0] {SEL_NONE, SEL_PIPE, SEL_MC} wb_sel_t;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_STALL} starve_st_t;

   typedef struct packed {
      logic [REG_W-1:0]  dst;
      logic [DATA_W-1:0] data;
   } mc_entry_t;

   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
      logic [NUM_REGS-1:0] v;
      v    = '0;
      v[r] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of MCU results; exposes every slot and its valid
// bit so the parent can build the busy-register mask.
module wb_fifo
   import wb_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  mc_entry_t                  wr_entry,
   input  logic                       pop,
   output mc_entry_t                  head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output mc_entry_t                  entries [DEPTH],
   output logic [DEPTH-1:0]           valid
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;
   mc_entry_t        mem [DEPTH];

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];
   assign entries = mem;

   // NOTE: payload storage is deliberately not reset; the valid bits alone decide what is live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_entry;
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         valid  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr         <= wr_ptr + PTR_W'(1);
            valid[wr_ptr]  <= 1'b1;
         end
         if (do_pop) begin
            rd_ptr         <= rd_ptr + PTR_W'(1);
            valid[rd_ptr]  <= 1'b0;
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the MEM/WB stage (always wins)
// and queued multi-cycle results, asking for a WB bubble when those starve.
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wb_reg_write,
   input  logic                wb_mem_to_reg,
   input  logic [DATA_W-1:0]   wb_alu_result,
   input  logic [DATA_W-1:0]   wb_data_load,
   input  logic [REG_W-1:0]    wb_dst,
   input  logic                mc_valid,
   output logic                mc_ready,
   input  logic [REG_W-1:0]    mc_dst,
   input  logic [DATA_W-1:0]   mc_data,
   output logic                rf_we,
   output logic [REG_W-1:0]    rf_waddr,
   output logic [DATA_W-1:0]   rf_wdata,
   output logic                stall_req,
   output logic [NUM_REGS-1:0] mc_busy
);

   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int WCNT_W = $clog2(STARVE_LIMIT + 1);

   logic              pipe_valid;
   logic              push;
   logic              pop;
   logic              drain;
   logic              full;
   logic              empty;
   logic [CNT_W-1:0]  count;
   mc_entry_t         new_entry;
   mc_entry_t         head;
   mc_entry_t         entries [DEPTH];
   logic [DEPTH-1:0]  valid;
   wb_sel_t           sel;
   starve_st_t        st;
   starve_st_t        st_nxt;
   logic [WCNT_W-1:0] wcnt;
   logic [WCNT_W-1:0] wcnt_nxt;

   assign pipe_valid = wb_reg_write && (wb_dst != '0);
   assign mc_ready   = !full;
   // Zero-destination results are acknowledged but never stored.
   assign push       = mc_valid && mc_ready && (mc_dst != '0);
   assign pop        = (sel == SEL_MC);
   assign drain      = pop && !push && (count == CNT_W'(1));
   assign new_entry  = '{dst: mc_dst, data: mc_data};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .wr_entry (new_entry),
      .pop      (pop),
      .head     (head),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .entries  (entries),
      .valid    (valid)
   );

   always_comb begin
      if (pipe_valid)  sel = SEL_PIPE;
      else if (!empty) sel = SEL_MC;
      else             sel = SEL_NONE;
   end

   always_comb begin
      mc_busy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i]) mc_busy = mc_busy | reg_onehot(entries[i].dst);
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      st_nxt   = st;
      wcnt_nxt = wcnt;
      unique case (st)
         ST_IDLE: begin
            wcnt_nxt = '0;
            if (push) st_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (sel == SEL_MC) begin
               wcnt_nxt = '0;
               if (drain) st_nxt = ST_IDLE;
            end else if (sel == SEL_PIPE) begin
               wcnt_nxt = wcnt + WCNT_W'(1);
               if (wcnt_nxt == WCNT_W'(STARVE_LIMIT)) st_nxt = ST_STALL;
            end
         end
         ST_STALL: begin
            if (sel == SEL_MC) begin
               wcnt_nxt = '0;
               st_nxt   = drain ? ST_IDLE : ST_WAIT;
            end
         end
         default: begin
            st_nxt   = ST_IDLE;
            wcnt_nxt = '0;
         end
      endcase
   end

   // NOTE: state and output registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= ST_IDLE;
         wcnt      <= '0;
         stall_req <= 1'b0;
         rf_we     <= 1'b0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
      end else begin
         st        <= st_nxt;
         wcnt      <= wcnt_nxt;
         stall_req <= (st_nxt == ST_STALL);
         unique case (sel)
            SEL_PIPE: begin
               rf_we    <= 1'b1;
               rf_waddr <= wb_dst;
               rf_wdata <= wb_mem_to_reg ? wb_data_load : wb_alu_result;
            end
            SEL_MC: begin
               rf_we    <= 1'b1;
               rf_waddr <= head.dst;
               rf_wdata <= head.data;
            end
            default: begin
               rf_we    <= 1'b0;
               rf_waddr <= '0;
               rf_wdata <= '0;
            end
         endcase
      end
   end

endmodule
